// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm target editor: FSM states, button
// events, field limits and the wrap-around step helper.
package alarm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EDIT_H,
        EDIT_M,
        EDIT_S,
        EDIT_LEN
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_OK,
        EV_MODE,
        EV_UP,
        EV_DOWN
    } event_e;

    localparam int BTN_OK   = 0;
    localparam int BTN_MODE = 1;
    localparam int BTN_UP   = 2;
    localparam int BTN_DOWN = 3;

    localparam logic [5:0] FIELD_MIN = 6'd0;
    localparam logic [5:0] HH_MAX    = 6'd23;
    localparam logic [5:0] MM_MAX    = 6'd59;
    localparam logic [5:0] SS_MAX    = 6'd59;
    localparam logic [5:0] LEN_MAX   = 6'd60;
    localparam logic [5:0] LEN_MIN   = 6'd1;

    localparam logic [16:0] SEC_PER_HOUR = 17'd3600;
    localparam logic [16:0] SEC_PER_MIN  = 17'd60;
    localparam logic [7:0]  IDLE_MASK    = 8'b0011_1111;

    // Same-cycle presses resolve as ok > mode > up > down; the rest are dropped.
    function automatic event_e arbitrate(input logic [3:0] pulses);
        if (pulses[BTN_OK])        return EV_OK;
        else if (pulses[BTN_MODE]) return EV_MODE;
        else if (pulses[BTN_UP])   return EV_UP;
        else if (pulses[BTN_DOWN]) return EV_DOWN;
        return EV_NONE;
    endfunction

    function automatic logic [5:0] step_wrap(input logic [5:0] value,
                                             input logic [5:0] lo,
                                             input logic [5:0] hi,
                                             input logic       up);
        if (up) return (value >= hi) ? lo : value + 6'd1;
        return (value <= lo) ? hi : value - 6'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton front end: 2-FF synchroniser, stable-time debouncer and a one-cycle
// press pulse. BTN_AUTOREPEAT_EN adds hold-to-repeat pulses on enabled instances.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
`ifdef BTN_AUTOREPEAT_EN
    , parameter int CLK_FREQ  = 100_000_000
    , parameter bit REPEAT_EN = 1'b0
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;
    logic             press_pulse;
    logic             pulse_d;

    // A press is accepted on the cycle the synchronised level has differed
    // from the stable level for DEBOUNCE_CYCLES consecutive samples.
    assign press_pulse = sync_q[1] && !stable_q && (cnt_q == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            pulse_q <= pulse_d;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q    <= '0;
                stable_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    if (REPEAT_EN) begin : g_repeat
        localparam int FIRST = (CLK_FREQ / 2 > 1) ? CLK_FREQ / 2 : 1;
        localparam int NEXT  = (CLK_FREQ / 8 > 1) ? CLK_FREQ / 8 : 1;
        localparam int REP_W = $clog2(FIRST + 1);

        logic [REP_W-1:0] rep_q;
        logic             held;
        logic             rep_fire;

        assign held     = stable_q && sync_q[1];
        assign rep_fire = held && (rep_q == '0) && !press_pulse;
        assign pulse_d  = press_pulse || rep_fire;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rep_q <= '0;
            end else if (press_pulse) begin
                rep_q <= REP_W'(FIRST - 1);
            end else if (!held) begin
                rep_q <= '0;
            end else if (rep_q == '0) begin
                rep_q <= REP_W'(NEXT - 1);
            end else begin
                rep_q <= rep_q - REP_W'(1);
            end
        end
    end else begin : g_no_repeat
        assign pulse_d = press_pulse;
    end
`else
    assign pulse_d = press_pulse;
`endif

    assign pulse_o = pulse_q;

endmodule

// File: rtl/alarm_setter.sv
// Button-driven editor for the alarm target (time of day, ring length, enable)
// and digit/mask source for the display. Macro BTN_AUTOREPEAT_EN enables up/down repeat.
module alarm_setter
    import alarm_pkg::*;
#(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int DEFAULT_SEC     = 10,
    parameter int DEFAULT_LEN     = 60,
    parameter int EDIT_TIMEOUT_S  = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_ok,
    output logic [16:0] tar_sec,
    output logic [5:0]  len,
    output logic        alarm_en,
    output logic        editing,
    output logic [3:0]  h1,
    output logic [3:0]  h2,
    output logic [3:0]  m1,
    output logic [3:0]  m2,
    output logic [3:0]  s1,
    output logic [3:0]  s2,
    output logic [7:0]  disp_mask
);

    localparam longint TO_CYCLES = longint'(EDIT_TIMEOUT_S) * longint'(CLK_FREQ);
    localparam int     TO_W      = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    localparam int PH_CYCLES = (CLK_FREQ / 4 > 1) ? CLK_FREQ / 4 : 1;
    localparam int PH_W      = $clog2(PH_CYCLES + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH_CYCLES - 1);

    logic [3:0] btn_raw;
    logic [3:0] pulse;
    event_e     ev;

    assign btn_raw = {btn_down, btn_up, btn_mode, btn_ok};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
            , .CLK_FREQ (CLK_FREQ)
            , .REPEAT_EN(i == BTN_UP || i == BTN_DOWN)
`endif
        ) u_db (
            .clk    (clk),
            .rst    (rst),
            .btn_i  (btn_raw[i]),
            .pulse_o(pulse[i])
        );
    end

    assign ev = arbitrate(pulse);

    state_e          state_q, state_d;
    logic [16:0]     tar_q, tar_d;
    logic [5:0]      len_q, len_d;
    logic            en_q, en_d;
    logic [5:0]      hh_q, hh_d, mm_q, mm_d, ss_q, ss_d, ln_q, ln_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            blink_q, blink_d;

    logic [5:0]  tar_hh, tar_mm, tar_ss;
    logic [16:0] tar_rem;

    assign tar_hh  = 6'(tar_q / SEC_PER_HOUR);
    assign tar_rem = tar_q % SEC_PER_HOUR;
    assign tar_mm  = 6'(tar_rem / SEC_PER_MIN);
    assign tar_ss  = 6'(tar_rem % SEC_PER_MIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            tar_q   <= 17'(DEFAULT_SEC);
            len_q   <= 6'(DEFAULT_LEN);
            en_q    <= 1'b0;
            hh_q    <= '0;
            mm_q    <= '0;
            ss_q    <= '0;
            ln_q    <= '0;
            to_q    <= '0;
            phase_q <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tar_q   <= tar_d;
            len_q   <= len_d;
            en_q    <= en_d;
            hh_q    <= hh_d;
            mm_q    <= mm_d;
            ss_q    <= ss_d;
            ln_q    <= ln_d;
            to_q    <= to_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        tar_d   = tar_q;
        len_d   = len_q;
        en_d    = en_q;
        hh_d    = hh_q;
        mm_d    = mm_q;
        ss_d    = ss_q;
        ln_d    = ln_q;
        to_d    = to_q + TO_W'(1);
        phase_d = phase_q;
        blink_d = blink_q;

        if (state_q == IDLE) begin
            case (ev)
                EV_MODE: begin
                    hh_d    = tar_hh;
                    mm_d    = tar_mm;
                    ss_d    = tar_ss;
                    ln_d    = len_q;
                    state_d = EDIT_H;
                end
                EV_OK:   en_d = ~en_q;
                default: ;
            endcase
        end else begin
            case (ev)
                EV_OK: begin
                    tar_d   = 17'(hh_q) * SEC_PER_HOUR + 17'(mm_q) * SEC_PER_MIN + 17'(ss_q);
                    len_d   = ln_q;
                    en_d    = 1'b1;
                    state_d = IDLE;
                end
                EV_MODE: begin
                    case (state_q)
                        EDIT_H:  state_d = EDIT_M;
                        EDIT_M:  state_d = EDIT_S;
                        EDIT_S:  state_d = EDIT_LEN;
                        default: state_d = EDIT_H;
                    endcase
                end
                EV_UP, EV_DOWN: begin
                    case (state_q)
                        EDIT_H:  hh_d = step_wrap(hh_q, FIELD_MIN, HH_MAX, ev == EV_UP);
                        EDIT_M:  mm_d = step_wrap(mm_q, FIELD_MIN, MM_MAX, ev == EV_UP);
                        EDIT_S:  ss_d = step_wrap(ss_q, FIELD_MIN, SS_MAX, ev == EV_UP);
                        default: ln_d = step_wrap(ln_q, LEN_MIN, LEN_MAX, ev == EV_UP);
                    endcase
                end
                default: begin
                    if (to_q == TO_LAST) begin
                        state_d = IDLE;
                        hh_d    = '0;
                        mm_d    = '0;
                        ss_d    = '0;
                        ln_d    = '0;
                    end
                end
            endcase
        end

        if (state_d == IDLE || ev != EV_NONE) to_d = '0;

        // Blink phase restarts on every state change so a new field starts visible.
        if (state_d != state_q) begin
            phase_d = '0;
            blink_d = 1'b0;
        end else if (state_q != IDLE) begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                blink_d = ~blink_q;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    logic [5:0] disp_hh, disp_mm, disp_ss;
    logic [1:0] sel_on;

    assign sel_on = {2{~blink_q}};

    always_comb begin
        disp_hh   = tar_hh;
        disp_mm   = tar_mm;
        disp_ss   = tar_ss;
        disp_mask = IDLE_MASK;
        case (state_q)
            EDIT_H: begin
                disp_hh   = hh_q;
                disp_mm   = mm_q;
                disp_ss   = ss_q;
                disp_mask = {2'b00, sel_on, 4'b1111};
            end
            EDIT_M: begin
                disp_hh   = hh_q;
                disp_mm   = mm_q;
                disp_ss   = ss_q;
                disp_mask = {4'b0011, sel_on, 2'b11};
            end
            EDIT_S: begin
                disp_hh   = hh_q;
                disp_mm   = mm_q;
                disp_ss   = ss_q;
                disp_mask = {6'b00_1111, sel_on};
            end
            EDIT_LEN: begin
                disp_hh   = '0;
                disp_mm   = '0;
                disp_ss   = ln_q;
                disp_mask = {6'b00_0000, sel_on};
            end
            default: ;
        endcase
    end

    assign h1 = 4'(disp_hh / 6'd10);
    assign h2 = 4'(disp_hh % 6'd10);
    assign m1 = 4'(disp_mm / 6'd10);
    assign m2 = 4'(disp_mm % 6'd10);
    assign s1 = 4'(disp_ss / 6'd10);
    assign s2 = 4'(disp_ss % 6'd10);

    assign tar_sec  = tar_q;
    assign len      = len_q;
    assign alarm_en = en_q;
    assign editing  = (state_q != IDLE);

endmodule

// File: tb/tb_alarm_setter.sv
// Self-checking bench for alarm_setter: directed scenarios plus random button
// presses compared against an arithmetic model of the editor.
module tb_alarm_setter;

    localparam int CLK_FREQ = 16;
    localparam int DEB      = 4;
    localparam int TO_S     = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  btn;              // [0]=ok [1]=mode [2]=up [3]=down
    logic [16:0] tar_sec;
    logic [5:0]  len;
    logic        alarm_en, editing;
    logic [3:0]  h1, h2, m1, m2, s1, s2;
    logic [7:0]  disp_mask;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: committed values, shadow fields, 0=idle 1=H 2=M 3=S 4=LEN.
    int m_state, m_tar, m_len, m_en, m_hh, m_mm, m_ss, m_ln;

    alarm_setter #(
        .CLK_FREQ       (CLK_FREQ),
        .DEBOUNCE_CYCLES(DEB),
        .DEFAULT_SEC    (10),
        .DEFAULT_LEN    (60),
        .EDIT_TIMEOUT_S (TO_S)
    ) u_dut (
        .clk      (clk),
        .rst      (rst_n),
        .btn_mode (btn[1]),
        .btn_up   (btn[2]),
        .btn_down (btn[3]),
        .btn_ok   (btn[0]),
        .tar_sec  (tar_sec),
        .len      (len),
        .alarm_en (alarm_en),
        .editing  (editing),
        .h1       (h1),
        .h2       (h2),
        .m1       (m1),
        .m2       (m2),
        .s1       (s1),
        .s2       (s2),
        .disp_mask(disp_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_tar = 10; m_len = 60; m_en = 0;
        m_hh = 0; m_mm = 0; m_ss = 0; m_ln = 0;
    endtask

    task automatic model_event(input int b);
        int d;
        if (m_state == 0) begin
            if (b == 1) begin
                m_hh = m_tar / 3600;
                m_mm = (m_tar / 60) % 60;
                m_ss = m_tar % 60;
                m_ln = m_len;
                m_state = 1;
            end else if (b == 0) begin
                m_en = (m_en == 0) ? 1 : 0;
            end
        end else begin
            d = (b == 2) ? 1 : -1;
            case (b)
                0: begin
                    m_tar = m_hh * 3600 + m_mm * 60 + m_ss;
                    m_len = m_ln;
                    m_en = 1;
                    m_state = 0;
                end
                1: m_state = (m_state == 4) ? 1 : m_state + 1;
                default: begin
                    case (m_state)
                        1: m_hh = (m_hh + d + 24) % 24;
                        2: m_mm = (m_mm + d + 60) % 60;
                        3: m_ss = (m_ss + d + 60) % 60;
                        default: m_ln = ((m_ln - 1 + d + 60) % 60) + 1;
                    endcase
                end
            endcase
        end
    endtask

    function automatic logic [23:0] exp_digits();
        int h, m, s;
        case (m_state)
            0: begin h = m_tar / 3600; m = (m_tar / 60) % 60; s = m_tar % 60; end
            4: begin h = 0; m = 0; s = m_ln; end
            default: begin h = m_hh; m = m_mm; s = m_ss; end
        endcase
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic check_outputs(input string tag);
        logic [7:0] sel, other;
        case (m_state)
            1: sel = 8'h30;
            2: sel = 8'h0C;
            3, 4: sel = 8'h03;
            default: sel = 8'h00;
        endcase
        other = (m_state == 4) ? 8'h00 : 8'h3F;
        check({tag, " tar_sec"}, 32'(tar_sec), m_tar);
        check({tag, " len"}, 32'(len), m_len);
        check({tag, " alarm_en"}, 32'(alarm_en), m_en);
        check({tag, " editing"}, 32'(editing), (m_state != 0) ? 1 : 0);
        check({tag, " digits"}, 32'({h1, h2, m1, m2, s1, s2}), 32'(exp_digits()));
        check({tag, " mask"}, 32'(disp_mask & ~sel), 32'(other & ~sel));
    endtask

    // Press button b for hold cycles, release for gap cycles; ends #1 after an edge.
    task automatic press(input int b, input int hold, input int gap);
        btn[b] = 1'b1;
        repeat (hold) @(posedge clk);
        #1;
        model_event(b);
        btn[b] = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic press_n(input int b, input int n);
        for (int k = 0; k < n; k++) press(b, 7, 7);
    endtask

    task automatic wait_timeout();
        repeat (45) @(posedge clk);
        #1;
        m_state = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset_low");
        check("reset mask", 32'(disp_mask), 32'h3F);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_rel");

        press(0, 8, 8);
        check("ok arms", 32'(alarm_en), 1);

        // Glitches shorter than the debounce window must not register.
        for (int g = 1; g <= 3; g++) begin
            btn[0] = 1'b1;
            repeat (g) @(posedge clk);
            #1 btn[0] = 1'b0;
            repeat (6) @(posedge clk);
            #1;
        end
        btn[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 btn[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_outputs("glitch");

        // Pulse at edge 6 after the raw edge, so the toggle appears after edge 7.
        btn[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) check("latency before", 32'(alarm_en), m_en);
            if (i == 7) begin
                model_event(0);
                check("latency after", 32'(alarm_en), m_en);
            end
        end
        btn[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Enter edit: selected hours start visible, then blank after a quarter second.
        btn[1] = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(posedge clk);
            #1;
            if (i == 7) begin
                model_event(1);
                check("blink entry", 32'(disp_mask), 32'h3F);
            end
            if (i == 11) check("blink off", 32'(disp_mask), 32'h0F);
        end
        btn[1] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_outputs("edit_entry");

        press_n(3, 17);
        check_outputs("hh7");
        press(1, 7, 7);
        press_n(2, 30);
        check_outputs("mm30");
        press(1, 7, 7);
        press_n(3, 5);
        check_outputs("ss5");
        press(1, 7, 7);
        press_n(3, 45);
        check_outputs("ln15");

        btn[0] = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk);
            #1;
            if (i == 6) check("commit early", 32'(tar_sec), m_tar);
        end
        model_event(0);
        check("commit tar", 32'(tar_sec), 27005);
        check("commit len", 32'(len), 15);
        check("commit en", 32'(alarm_en), 1);
        btn[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_outputs("commit");

        // Wrap-around at field limits.
        press(1, 7, 7);
        press_n(1, 3);
        press_n(3, 15);
        check("len wrap down", 32'({s1, s2}), 32'h60);
        press(2, 7, 7);
        check("len wrap up", 32'({s1, s2}), 32'h01);
        press(3, 7, 7);
        check("len back", 32'({s1, s2}), 32'h60);
        press(1, 7, 7);
        press_n(2, 16);
        check("hh at 23", 32'({h1, h2}), 32'h23);
        press(2, 7, 7);
        check("hh wrap", 32'({h1, h2}), 32'h00);
        check_outputs("wrap");

        // Idle past the edit timeout: edit abandoned, committed values unchanged.
        wait_timeout();
        check("timeout editing", 32'(editing), 0);
        check("timeout tar", 32'(tar_sec), 27005);
        check_outputs("timeout");

        // ok and up in the same cycle while editing minutes: commit only.
        press(1, 7, 7);
        press(2, 7, 7);
        press(1, 7, 7);
        btn = 4'b0101;
        repeat (8) @(posedge clk);
        #1;
        model_event(0);
        btn = '0;
        repeat (8) @(posedge clk);
        #1;
        check("simul tar", 32'(tar_sec), 30605);
        check_outputs("simul");

        // Random presses against the model.
        for (int n = 0; n < 60; n++) begin
            int r, b;
            r = int'($urandom_range(99));
            b = (r < 15) ? 0 : (r < 35) ? 1 : (r < 70) ? 2 : 3;
            press(b, int'($urandom_range(10, 7)), int'($urandom_range(10, 7)));
            if ($urandom_range(9) == 0) wait_timeout();
            check_outputs("random");
        end

        // Reset while editing seconds aborts immediately.
        for (int k = 0; k < 6 && m_state != 3; k++) press(1, 7, 7);
        check("reach EDIT_S", 32'(m_state), 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("midedit_rst");
        check("midedit mask", 32'(disp_mask), 32'h3F);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
